stream_serializer_tx: RTL
=========================

Name: stream_serializer_tx

Overview:
- Single-clock transmitter for the val/ready word stream consumed by the stream FIFO receive end.
- Accepts one wide word (RATIO × PAYLOAD_BITS) on a val/ready upstream port and emits RATIO narrow beats, LSB slice first, toward a FIFO write port.
- The downstream FIFO writes on every val cycle regardless of full. This block therefore never asserts val_out while ready_downward is low.

Parameters:
- PAYLOAD_BITS, 32, width of each emitted beat.
- RATIO, 4, beats per wide word; legal range ≥ 1.
- WIDE_BITS, PAYLOAD_BITS*RATIO, localparam; width of din.
- CNT_BITS, max(1, clog2(RATIO)), localparam; beat counter width.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDE_BITS  wide word from the producer.
- val_in  input  1  din is valid.
- ready_upward  output  1  block can accept din this cycle.
- dout  output  PAYLOAD_BITS  current beat.
- val_out  output  1  beat valid; doubles as the downstream write enable.
- last_out  output  1  current beat is the final slice of its wide word.
- ready_downward  input  1  downstream not full.

Behaviour:
- States:
  - IDLE (0): no word held.
  - SEND (1): shift register holds ≥1 unsent beat.
- Reset (sync, dominant over all other inputs):
  - state=IDLE, cnt=0, shreg=0.
  - Outputs: ready_upward=0 during the reset cycle, 1 on the first cycle after reset; val_out=0; last_out=0; dout=0.
- Upstream accept:
  - Condition: val_in && ready_upward.
  - ready_upward = !reset && (state==IDLE || (state==SEND && cnt==RATIO-1 && ready_downward)). This is combinational and allows back-to-back words with no bubble.
- Accept action: shreg<=din, cnt<=0, state<=SEND.
- Latency: first beat is presented the cycle after accept.
- Beat output in SEND:
  - dout = shreg[PAYLOAD_BITS-1:0].
  - val_out = ready_downward (combinational gate).
  - last_out = val_out && cnt==RATIO-1.
- In IDLE: dout=0, val_out=0, last_out=0.
- Beat transfer condition: state==SEND && ready_downward.
  - Non-last beat (cnt<RATIO-1): shreg shifts right by PAYLOAD_BITS with zero fill; cnt increments.
  - Last beat with simultaneous accept: reload shreg, cnt=0, stay in SEND.
  - Last beat without accept: state<=IDLE, cnt=0.
- ready_downward low in SEND: hold shreg, cnt and dout; val_out=0; no beat is lost or duplicated.
- RATIO=1: every beat is last; the block behaves as a one-entry register stage with a gated valid.
- val_in while not ready: ignored; din is not sampled and the producer must hold it.
- Reset mid-word: remaining beats are discarded, with no partial flush.
- Throughput: one beat per cycle while ready_downward is high; a sustained source gives 100% downstream utilization.

Decomposition:
- Shared package:
  - State encodings ST_IDLE=1'b0 and ST_SEND=1'b1, matching the existing NODATA/VALDATA one-bit style.
  - clog2 function with min-1 clamp.
- Single module; no sub-module needed (shift register + counter + 2-state FSM, ~150 lines).

Test Plan:
- Basic word:
  - Setup: PAYLOAD_BITS=32, RATIO=4, ready_downward=1.
  - Stimulus: din=0x44444444_33333333_22222222_11111111, val_in pulse.
  - Required response: dout=0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles 1–4 after accept; val_out=1 on each; last_out only on cycle 4; ready_upward=0 on cycles 1–3.
- Backpressure:
  - Stimulus: same word, ready_downward=0 for 3 cycles after the 2nd beat.
  - Required response: val_out=0 and dout held at 0x33333333 during the stall; after release, 0x33333333 then 0x44444444; exactly 4 val_out pulses total.
- Back-to-back:
  - Stimulus: two words A and B, val_in held high, ready_downward=1.
  - Required response: 8 consecutive val_out cycles, no gap; B accepted in the same cycle as A's last beat; last_out on beats 4 and 8.
- Reset mid-word:
  - Stimulus: assert reset after the 2nd beat for 1 cycle.
  - Required response: val_out=0 and ready_upward=0 in the reset cycle; ready_upward=1 the next cycle; no further beats of the old word appear.
- RATIO=1:
  - Stimulus: din=0xA5A5A5A5, 0x5A5A5A5A streamed with val_in high, ready_downward toggling 1,0,1.
  - Required response: each word emitted once with last_out=1; never val_out=1 while ready_downward=0.
- Idle:
  - Stimulus: no val_in for 10 cycles.
  - Required response: dout=0, val_out=0, ready_upward=1 throughout.

Source files
------------

// File: rtl/stream_serializer_tx_pkg.sv
// Shared definitions for the wide-to-narrow stream transmitter.
package stream_serializer_tx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Ceiling log2, never less than one bit so RATIO=1 still has a legal counter.
   function automatic int clog2_min1(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      if (result < 1) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/stream_serializer_tx.sv
// Serialises one RATIO*PAYLOAD_BITS word into RATIO beats, LSB slice first,
// for a FIFO write port that writes on every val cycle.
//
//   state   | meaning
//   --------+--------------------------------------------
//   ST_IDLE | no word held, ready for a new word
//   ST_SEND | shift register holds at least one unsent beat
module stream_serializer_tx
   import stream_serializer_tx_pkg::*;
#(
   parameter int PAYLOAD_BITS = 32,
   parameter int RATIO        = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PAYLOAD_BITS*RATIO-1:0] din,
   input  logic                          val_in,
   output logic                          ready_upward,
   output logic [PAYLOAD_BITS-1:0]       dout,
   output logic                          val_out,
   output logic                          last_out,
   input  logic                          ready_downward
);

   localparam int WIDE_BITS = PAYLOAD_BITS * RATIO;
   localparam int CNT_BITS  = clog2_min1(RATIO);
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(RATIO - 1);

   state_e                state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [WIDE_BITS-1:0]  shreg_q, shreg_d;

   logic cnt_last;
   logic accept;
   logic beat;

   assign cnt_last = (cnt_q == CNT_LAST);
   assign beat     = (state_q == ST_SEND) && ready_downward;

   // Taking a new word on the last beat keeps the downstream stream gap-free.
   assign ready_upward = !reset && ((state_q == ST_IDLE) || (cnt_last && beat));
   assign accept       = val_in && ready_upward;

   // Gated by reset so the reset cycle presents nothing even if a word was in flight.
   assign val_out  = !reset && beat;
   assign last_out = val_out && cnt_last;
   assign dout     = (!reset && state_q == ST_SEND) ? shreg_q[PAYLOAD_BITS-1:0]
                                                    : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;

      if (beat) begin
         if (!cnt_last) begin
            shreg_d = shreg_q >> PAYLOAD_BITS;
            cnt_d   = cnt_q + CNT_BITS'(1);
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end

      if (accept) begin
         shreg_d = din;
         cnt_d   = '0;
         state_d = ST_SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

endmodule
